// File: rtl/fpu_megafunction_arbiter.sv
// Round-robin share of one fixed-latency FP megafunction between two requesters, with tag routing
// and credit-protected response FIFOs. Define FPU_ARB_STATS_EN to add issue/conflict/stall counters.
module fpu_megafunction_arbiter #(
   parameter int W          = 64,
   parameter int OPW        = 2,
   parameter int LATENCY    = 7,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [W-1:0]   req0_opa,
   input  logic [W-1:0]   req0_opb,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [W-1:0]   req1_opa,
   input  logic [W-1:0]   req1_opb,
   input  logic [OPW-1:0] req1_op,
   output logic [W-1:0]   mf_dataa,
   output logic [W-1:0]   mf_datab,
   output logic [OPW-1:0] mf_op,
   output logic           mf_in_valid,
   input  logic [W-1:0]   mf_result,
   output logic           resp0_valid,
   input  logic           resp0_ready,
   output logic [W-1:0]   resp0_data,
   output logic           resp1_valid,
   input  logic           resp1_ready,
   output logic [W-1:0]   resp1_data
`ifdef FPU_ARB_STATS_EN
   ,
   output logic [31:0]    stat_issue0,
   output logic [31:0]    stat_issue1,
   output logic [31:0]    stat_conflict,
   output logic [31:0]    stat_stall
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [1:0]          vld, elig, grant, wr, pop, rdy;
   logic [1:0][W-1:0]   opa, opb;
   logic [1:0][OPW-1:0] op;
   logic [1:0][CW-1:0]  credit, cnt;
   logic [1:0][PW-1:0]  rp, wp;
   logic [W-1:0]        mem [2][FIFO_DEPTH];
   logic                last_grant, sel, issue;
   logic [LATENCY-1:0]  tag_vld, tag_id;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign vld = {req1_valid, req0_valid};
   assign opa = {req1_opa, req0_opa};
   assign opb = {req1_opb, req0_opb};
   assign op  = {req1_op, req0_op};
   assign rdy = {resp1_ready, resp0_ready};

   // Ready depends only on request side and registered state; never on resp*_ready.
   always_comb begin
      elig  = 2'b00;
      grant = 2'b00;
      for (int i = 0; i < 2; i++) elig[i] = vld[i] && (credit[i] != '0);
      if (!rst) begin
         if (elig == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
         else               grant = elig;
      end
   end

   assign issue       = |grant;
   assign sel         = grant[1];
   assign req0_ready  = grant[0];
   assign req1_ready  = grant[1];
   assign mf_in_valid = issue;
   assign mf_dataa    = rst ? '0 : opa[sel];
   assign mf_datab    = rst ? '0 : opb[sel];
   assign mf_op       = rst ? '0 : op[sel];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld    <= '0;
         tag_id     <= '0;
         last_grant <= 1'b1;
      end else begin
         for (int k = LATENCY - 1; k > 0; k--) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_id[k]  <= tag_id[k-1];
         end
         tag_vld[0] <= issue;
         tag_id[0]  <= sel;
         if (issue) last_grant <= sel;
      end
   end

   always_comb begin
      wr  = 2'b00;
      pop = 2'b00;
      for (int i = 0; i < 2; i++) begin
         wr[i]  = tag_vld[LATENCY-1] && (tag_id[LATENCY-1] == 1'(i));
         pop[i] = (cnt[i] != '0) && rdy[i];
      end
   end

   // Credit counts in-flight plus buffered results, so a tail write always finds room.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            credit[i] <= CW'(FIFO_DEPTH);
            cnt[i]    <= '0;
            rp[i]     <= '0;
            wp[i]     <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem[i][k] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (grant[i] && !pop[i])      credit[i] <= credit[i] - CW'(1);
            else if (pop[i] && !grant[i]) credit[i] <= credit[i] + CW'(1);
            if (wr[i]) begin
               mem[i][wp[i]] <= mf_result;
               wp[i]         <= nxt(wp[i]);
            end
            if (pop[i]) rp[i] <= nxt(rp[i]);
            if (wr[i] && !pop[i])      cnt[i] <= cnt[i] + CW'(1);
            else if (pop[i] && !wr[i]) cnt[i] <= cnt[i] - CW'(1);
         end
      end
   end

   assign resp0_valid = cnt[0] != '0;
   assign resp1_valid = cnt[1] != '0;
   assign resp0_data  = mem[0][rp[0]];
   assign resp1_data  = mem[1][rp[1]];

`ifdef FPU_ARB_STATS_EN
   logic conflict, stall;
   assign conflict = (vld == 2'b11) && (grant == 2'b01 || grant == 2'b10);
   assign stall    = (vld[0] && credit[0] == '0) || (vld[1] && credit[1] == '0);

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issue0   <= '0;
         stat_issue1   <= '0;
         stat_conflict <= '0;
         stat_stall    <= '0;
      end else begin
         stat_issue0   <= sat_inc(stat_issue0, grant[0]);
         stat_issue1   <= sat_inc(stat_issue1, grant[1]);
         stat_conflict <= sat_inc(stat_conflict, conflict);
         stat_stall    <= sat_inc(stat_stall, stall);
      end
   end
`endif
endmodule

// File: tb/tb_fpu_megafunction_arbiter.sv
// Bench for fpu_megafunction_arbiter: megafunction model, scoreboard per requester, directed steps
// and a randomized phase. Stats checks are compiled when FPU_ARB_STATS_EN is defined.
module tb_fpu_megafunction_arbiter;
   localparam int W = 64, OPW = 2, L = 7, D = 4;

   logic clk, rst;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_opa, req0_opb, req1_opa, req1_opb;
   logic [OPW-1:0] req0_op, req1_op, mf_op;
   logic [W-1:0] mf_dataa, mf_datab, mf_result;
   logic mf_in_valid;
   logic resp0_valid, resp0_ready, resp1_valid, resp1_ready;
   logic [W-1:0] resp0_data, resp1_data;
`ifdef FPU_ARB_STATS_EN
   logic [31:0] stat_issue0, stat_issue1, stat_conflict, stat_stall;
`endif

   int tests = 0, fails = 0, cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   fpu_megafunction_arbiter #(.W(W), .OPW(OPW), .LATENCY(L), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
      .req0_opb(req0_opb), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
      .req1_opb(req1_opb), .req1_op(req1_op),
      .mf_dataa(mf_dataa), .mf_datab(mf_datab), .mf_op(mf_op), .mf_in_valid(mf_in_valid),
      .mf_result(mf_result),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data)
`ifdef FPU_ARB_STATS_EN
      , .stat_issue0(stat_issue0), .stat_issue1(stat_issue1),
      .stat_conflict(stat_conflict), .stat_stall(stat_stall)
`endif
   );

   function automatic logic [63:0] fp_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
      real x, y, r;
      x = $bitstoreal(a);
      y = $bitstoreal(b);
      case (o)
         2'd0:    r = x + y;
         2'd1:    r = x - y;
         2'd2:    r = x * y;
         default: r = x / y;
      endcase
      return $realtobits(r);
   endfunction

   // Megafunction model: no stall, result appears LATENCY cycles after sampling.
   logic [W-1:0] mf_pipe [L];
   always @(posedge clk) begin
      for (int k = L - 1; k > 0; k--) mf_pipe[k] <= mf_pipe[k-1];
      mf_pipe[0] <= fp_op(mf_op, mf_dataa, mf_datab);
   end
   assign mf_result = mf_pipe[L-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: credits, last winner, and per-requester queues of {result, due cycle}.
   typedef struct { logic [W-1:0] data; int due; } exp_t;
   exp_t q0[$], q1[$];
   int cr0, cr1, lg;
   logic e0, e1, g0, g1, ev0, ev1;
`ifdef FPU_ARB_STATS_EN
   int s_i0, s_i1, s_cf, s_st;
`endif

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         chk("rst_req0_ready", req0_ready, 0);
         chk("rst_req1_ready", req1_ready, 0);
         chk("rst_mf_in_valid", mf_in_valid, 0);
         chk("rst_resp0_valid", resp0_valid, 0);
         chk("rst_resp1_valid", resp1_valid, 0);
         chk("rst_resp0_data", resp0_data, 0);
         chk("rst_resp1_data", resp1_data, 0);
         chk("rst_mf_dataa", mf_dataa, 0);
         chk("rst_mf_op", mf_op, 0);
         q0.delete(); q1.delete();
         cr0 = D; cr1 = D; lg = 1;
`ifdef FPU_ARB_STATS_EN
         s_i0 = 0; s_i1 = 0; s_cf = 0; s_st = 0;
`endif
      end else begin
         e0 = req0_valid && cr0 > 0;
         e1 = req1_valid && cr1 > 0;
         g0 = e0 && (!e1 || lg == 1);
         g1 = e1 && (!e0 || lg == 0);
         if (req0_valid) chk("req0_ready", req0_ready, g0);
         if (req1_valid) chk("req1_ready", req1_ready, g1);
         chk("mf_in_valid", mf_in_valid, g0 || g1);
         if (g0 || g1) begin
            chk("mf_dataa", mf_dataa, g0 ? req0_opa : req1_opa);
            chk("mf_datab", mf_datab, g0 ? req0_opb : req1_opb);
            chk("mf_op", mf_op, g0 ? req0_op : req1_op);
         end
         ev0 = q0.size() > 0 && q0[0].due <= cyc;
         ev1 = q1.size() > 0 && q1[0].due <= cyc;
         chk("resp0_valid", resp0_valid, ev0);
         chk("resp1_valid", resp1_valid, ev1);
         if (ev0) chk("resp0_data", resp0_data, q0[0].data);
         if (ev1) chk("resp1_data", resp1_data, q1[0].data);
`ifdef FPU_ARB_STATS_EN
         if (g0) s_i0++;
         if (g1) s_i1++;
         if (req0_valid && req1_valid && (g0 != g1)) s_cf++;
         if ((req0_valid && cr0 == 0) || (req1_valid && cr1 == 0)) s_st++;
`endif
         if (g0) begin q0.push_back('{fp_op(req0_op, req0_opa, req0_opb), cyc + L + 1}); cr0--; lg = 0; end
         if (g1) begin q1.push_back('{fp_op(req1_op, req1_opa, req1_opb), cyc + L + 1}); cr1--; lg = 1; end
         if (ev0 && resp0_ready) begin void'(q0.pop_front()); cr0++; end
         if (ev1 && resp1_ready) begin void'(q1.pop_front()); cr1++; end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_ops();
      req0_opa = $realtobits(real'($urandom_range(1, 1000)));
      req0_opb = $realtobits(real'($urandom_range(1, 1000)));
      req1_opa = $realtobits(real'($urandom_range(1, 1000)));
      req1_opb = $realtobits(real'($urandom_range(1, 1000)));
      req0_op  = OPW'($urandom_range(0, 3));
      req1_op  = OPW'($urandom_range(0, 3));
   endtask

   task automatic drain();
      req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
      repeat (L + D + 4) step();
   endtask

   // One req0 operation: issue now, nothing for LATENCY cycles, result on the next.
   task automatic probe(input string pre, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] o, input logic [63:0] exp);
      req0_opa = a; req0_opb = b; req0_op = o; req0_valid = 1; resp0_ready = 1;
      @(negedge clk);
      chk({pre, "_issue"}, mf_in_valid, 1);
      chk({pre, "_ready"}, req0_ready, 1);
      step();
      req0_valid = 0;
      for (int k = 1; k <= L + 1; k++) begin
         @(negedge clk);
         if (k <= L) chk({pre, "_early"}, resp0_valid, 0);
         else begin
            chk({pre, "_valid"}, resp0_valid, 1);
            chk({pre, "_data"}, resp0_data, exp);
         end
      end
      step();
   endtask

   initial begin
      logic exp0;
      int n;
      rst = 1;
      req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
      rnd_ops();
      #1;
      chk("init_resp0_valid", resp0_valid, 0);
      chk("init_req0_ready", req0_ready, 0);
      repeat (3) step();
      rst = 0;
      repeat (6) step();

      probe("t1", 64'h3FF0000000000000, 64'h4000000000000000, 2'd0, 64'h4008000000000000);

      // Both contending: req0 won last, so req1 takes the first tie.
      req0_valid = 1; req1_valid = 1; rnd_ops();
      exp0 = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("alt_req0", req0_ready, exp0);
         chk("alt_req1", req1_ready, !exp0);
         exp0 = !exp0;
         step();
         rnd_ops();
      end
      drain();

      // Credit exhaustion on req0, then a single-cycle pop frees exactly one slot.
      resp0_ready = 0; req0_valid = 1; n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (mf_in_valid && req0_ready) n++;
         step();
         rnd_ops();
      end
      chk("cred_issues", n, D);
      repeat (6) step();
      @(negedge clk);
      chk("cred_blocked", req0_ready, 0);
      step();
      resp0_ready = 1;
      @(negedge clk);
      chk("cred_pop_cycle", req0_ready, 0);
      step();
      resp0_ready = 0;
      @(negedge clk);
      chk("cred_reissue", req0_ready, 1);
      chk("cred_reissue_mf", mf_in_valid, 1);
      step();
      @(negedge clk);
      chk("cred_reblocked", req0_ready, 0);
      drain();

      // Asynchronous reset in mid-cycle with operations in flight.
      req0_valid = 1; req1_valid = 1; rnd_ops();
      repeat (3) step();
      #2;
      rst = 1;
      #1;
      chk("arst_req0_ready", req0_ready, 0);
      chk("arst_req1_ready", req1_ready, 0);
      chk("arst_mf_in_valid", mf_in_valid, 0);
      chk("arst_resp0_valid", resp0_valid, 0);
      chk("arst_resp1_valid", resp1_valid, 0);
      chk("arst_resp0_data", resp0_data, 0);
      chk("arst_mf_datab", mf_datab, 0);
      req0_valid = 0; req1_valid = 0;
      repeat (2) step();
      rst = 0;
      repeat (2) step();
      probe("t5", 64'h4014000000000000, 64'h4000000000000000, 2'd2, 64'h4024000000000000);

      // Randomized traffic, including full FIFOs with simultaneous pop and write.
      for (int k = 0; k < 400; k++) begin
         req0_valid  = $urandom_range(0, 3) != 0;
         req1_valid  = $urandom_range(0, 3) != 0;
         resp0_ready = $urandom_range(0, 2) != 0;
         resp1_ready = $urandom_range(0, 1) != 0;
         rnd_ops();
         step();
      end
      drain();

`ifdef FPU_ARB_STATS_EN
      chk("stat_issue0", stat_issue0, 32'(s_i0));
      chk("stat_issue1", stat_issue1, 32'(s_i1));
      chk("stat_conflict", stat_conflict, 32'(s_cf));
      chk("stat_stall", stat_stall, 32'(s_st));
      force dut.stat_issue0 = 32'hFFFF_FFFF;
      step();
      release dut.stat_issue0;
      req0_valid = 1;
      @(negedge clk);
      chk("sat_issue_happens", mf_in_valid, 1);
      step();
      req0_valid = 0;
      step();
      chk("stat_issue0_sat", stat_issue0, 32'hFFFF_FFFF);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
